rr_arb_mux: RTL
===============

RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter N, default 4: number of request ports; SHALL be a power of 2, 2..16.
REQ-002 Parameter W, default 8: data width per port.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  N  per-port request-valid flags.
REQ-006 in_data  input  N x W  per-port data.
REQ-007 in_ready  output  N  one-hot grant/accept, or all zero.
REQ-008 out_valid  output  1  registered output holds a word.
REQ-009 out_data  output  W  registered selected word.
REQ-010 out_src  output  log2(N)  index of the port that supplied out_data.
REQ-011 out_ready  input  1  downstream accepts the word.

Function
REQ-012 Transfer rules: input transfer on port i when in_valid[i] && in_ready[i]; output transfer when out_valid && out_ready.
REQ-013 can_load = !out_valid || out_ready, combinational; in_ready SHALL be all zero when can_load = 0.
REQ-014 When can_load = 1 and any in_valid is set, exactly one in_ready bit SHALL be set: the first valid port found scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-015 in_ready SHALL NOT depend on in_data; in_ready[i] SHALL be 0 whenever in_valid[i] = 0.
REQ-016 On a grant to port g: out_data <= in_data[g], out_src <= g, out_valid <= 1, ptr <= (g+1) mod N, all on the next edge; latency is 1 cycle.
REQ-017 When can_load = 1 and no in_valid is set: out_valid <= 0; ptr, out_data and out_src SHALL hold.
REQ-018 When can_load = 0: out_valid, out_data, out_src and ptr SHALL hold.
REQ-019 Output drains and a new word loads in the same cycle, giving full throughput of 1 word/cycle.
REQ-020 Fairness: with all N ports continuously valid and out_ready = 1, grants SHALL rotate ptr, ptr+1, ...; no port waits more than N-1 grants.
REQ-021 Wrap-around: a grant to port N-1 SHALL set ptr to 0.
REQ-022 A single valid port SHALL be granted every cycle regardless of ptr.
REQ-023 in_valid deasserted before a grant SHALL drop the request with no state change.

Reset
REQ-024 While rst = 1 at an edge, the block SHALL set out_valid = 0, out_data = 0, out_src = 0 and ptr = 0.
REQ-025 While rst = 1, in_ready SHALL be all zero.
REQ-026 Reset mid-operation SHALL discard the held word; the next grant after reset SHALL start scanning at port 0.

Structure
REQ-027 Package rr_arb_mux_pkg SHALL hold the default N and W values and the ptr/index width constant $clog2(N).
REQ-028 Sub-module rr_grant SHALL be a purely combinational block: inputs ptr, in_valid and enable; outputs a one-hot grant and its index.
REQ-029 Data selection SHALL be an index-driven multiplexer from in_data to the output register.
REQ-030 The block SHALL have no latches; every register SHALL be reset per REQ-024.

Verification
REQ-031 Reset check: assert rst with in_valid = 4'b1111 -> out_valid = 0, in_ready = 0; first cycle after reset with all ports valid -> in_ready = 4'b0001.
REQ-032 Rotation: in_valid = 4'b1111 and out_ready = 1 for 8 cycles, in_data[i] = 8'hA0+i -> out_src = 0,1,2,3,0,1,2,3 and out_data = A0..A3 repeating.
REQ-033 Skip and wrap: ptr = 3 and in_valid = 4'b0110 -> grant port 1 and set ptr = 2; next cycle with the same request -> grant port 2.
REQ-034 Backpressure: hold out_ready = 0 for 3 cycles with out_valid = 1 and out_data = 8'h55 -> in_ready = 0, out_data stays 8'h55; on release, the next grant occurs in the same cycle.
REQ-035 Idle: in_valid = 0 with out_ready = 1 -> out_valid falls to 0 after 1 cycle, ptr unchanged.
REQ-036 Mid-stream reset: pulse rst for 1 cycle during REQ-032 -> output flushes, and the scan resumes from port 0.

Source files
------------

// File: rtl/rr_arb_mux_pkg.sv
// Shared constants for the round-robin arbiter/multiplexer.
package rr_arb_mux_pkg;

    // Default number of request ports (power of two, 2..16).
    localparam int unsigned DEF_N = 4;

    // Default data width per port.
    localparam int unsigned DEF_W = 8;

    // Width of the rotation pointer and of the source index for DEF_N ports.
    localparam int unsigned DEF_IDX_W = $clog2(DEF_N);

    // Index width for an arbitrary port count; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb_mux_grant.sv
// Combinational round-robin grant: picks the first valid port at or after ptr.
module rr_grant
    import rr_arb_mux_pkg::*;
#(
    parameter int unsigned N  = DEF_N,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  in_valid,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          hit
);

    logic [IW-1:0] pos;
    logic          found;

    // Scan ptr, ptr+1, ... with natural IW-bit wrap (N is a power of two).
    always_comb begin
        grant = '0;
        idx   = '0;
        pos   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = ptr + IW'(k);
            if (!found && in_valid[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
        if (!enable) begin
            grant = '0;
            found = 1'b0;
        end
        hit = found;
    end

endmodule

// File: rtl/rr_arb_mux.sv
// Round-robin N:1 arbiter feeding a single registered output stage.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int unsigned N = DEF_N,
    parameter int unsigned W = DEF_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N-1:0]                in_valid,
    input  logic [N-1:0][W-1:0]         in_data,
    output logic [N-1:0]                in_ready,
    output logic                        out_valid,
    output logic [W-1:0]                out_data,
    output logic [idx_width(N)-1:0]     out_src,
    input  logic                        out_ready
);

    localparam int unsigned IW = idx_width(N);

    logic [IW-1:0] ptr;
    logic [IW-1:0] gnt_idx;
    logic [N-1:0]  grant;
    logic          hit;
    logic          can_load;
    logic          enable;
    logic [W-1:0]  sel_data;

    // Output register is free when empty or being drained this cycle.
    always_comb begin
        can_load = !out_valid || out_ready;
        enable   = can_load && !rst;
    end

    rr_grant #(
        .N  (N),
        .IW (IW)
    ) u_grant (
        .ptr      (ptr),
        .in_valid (in_valid),
        .enable   (enable),
        .grant    (grant),
        .idx      (gnt_idx),
        .hit      (hit)
    );

    // Grant vector doubles as the per-port accept strobe.
    always_comb begin
        in_ready = grant;
    end

    // Index-driven data select from the granted port.
    always_comb begin
        sel_data = in_data[gnt_idx];
    end

    // Output stage and rotation pointer; load on grant, empty on idle, hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else if (can_load) begin
            if (hit) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_src   <= gnt_idx;
                ptr       <= gnt_idx + IW'(1);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
